// File: rtl/result_drain.sv
// rtl/result_drain.sv - drains one result SRAM bank row by row onto a valid/ready word stream
module result_drain #(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH        = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    drain_start,
  input  logic [1:0]                              drain_bank,
  input  logic [ADDR_WIDTH:0]                     drain_rows,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_a,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_b,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]            out_data,
  output logic                                    out_last,
  output logic                                    drain_busy,
  output logic                                    drain_done,
  output logic                                    drain_err
);

  localparam int ROW_W      = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int WORD_IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int ROWS_W     = ADDR_WIDTH + 1;
  localparam int MAX_ROWS_I = 1 << ADDR_WIDTH;
  localparam logic [ROWS_W-1:0]     MAX_ROWS  = ROWS_W'(MAX_ROWS_I);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic [1:0]              bank_q;
  logic [ROWS_W-1:0]       rows_q;
  logic [ROWS_W-1:0]       row_idx;
  logic [WORD_IDX_W-1:0]   word_idx;
  logic [ROW_W-1:0]        row_buf;
  logic [ROW_W-1:0]        sel_rdata;
  logic                    drain_err_q;
  logic                    start_ok;
  logic                    handshake;
  logic                    row_last;
  logic                    word_last;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign start_ok  = drain_start && (drain_bank != 2'd3) &&
                     (drain_rows != '0) && (drain_rows <= MAX_ROWS);
  assign handshake = (state == S_SEND) && out_ready;
  assign row_last  = (row_idx == rows_q - ROWS_W'(1));
  assign word_last = (word_idx == LAST_WORD);
  assign next_addr = row_idx[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);

  always_comb begin
    sel_rdata = sram_rdata_a;
    case (bank_q)
      2'd1:    sel_rdata = sram_rdata_b;
      2'd2:    sel_rdata = sram_rdata_c;
      default: sel_rdata = sram_rdata_a;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_SEND;
      S_SEND:  if (handshake && word_last) state_next = row_last ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      bank_q       <= '0;
      rows_q       <= '0;
      row_idx      <= '0;
      word_idx     <= '0;
      row_buf      <= '0;
      drain_err_q  <= 1'b0;
      sram_raddr_a <= '0;
      sram_raddr_b <= '0;
      sram_raddr_c <= '0;
    end else begin
      state       <= state_next;
      drain_err_q <= (state == S_IDLE) && drain_start && !start_ok;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            bank_q       <= drain_bank;
            rows_q       <= drain_rows;
            row_idx      <= '0;
            sram_raddr_a <= '0;
            sram_raddr_b <= '0;
            sram_raddr_c <= '0;
          end
        end
        S_LOAD: begin
          row_buf  <= sel_rdata;
          word_idx <= '0;
        end
        S_SEND: begin
          if (handshake) begin
            word_idx <= word_idx + WORD_IDX_W'(1);
            // The address moves only on a row change so FETCH sees it already registered.
            if (word_last && !row_last) begin
              row_idx <= row_idx + ROWS_W'(1);
              case (bank_q)
                2'd1:    sram_raddr_b <= next_addr;
                2'd2:    sram_raddr_c <= next_addr;
                default: sram_raddr_a <= next_addr;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state == S_SEND);
  assign out_data   = row_buf[word_idx*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
  assign out_last   = (state == S_SEND) && row_last && word_last;
  assign drain_busy = (state != S_IDLE);
  assign drain_done = (state == S_DONE);
  assign drain_err  = drain_err_q;

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - directed self-checking bench for result_drain
module tb_result_drain;

  localparam int AS  = 32;
  localparam int OW  = 32;
  localparam int AW  = 6;
  localparam int RW  = AS * OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drain_start = 1'b0;
  logic [1:0]    drain_bank = '0;
  logic [AW:0]   drain_rows = '0;
  logic [AW-1:0] sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [RW-1:0] sram_rdata_a = '0, sram_rdata_b = '0, sram_rdata_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_last, drain_busy, drain_done, drain_err;

  int total = 0;
  int bad   = 0;

  result_drain #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .drain_start(drain_start), .drain_bank(drain_bank), .drain_rows(drain_rows),
    .sram_raddr_a(sram_raddr_a), .sram_raddr_b(sram_raddr_b), .sram_raddr_c(sram_raddr_c),
    .sram_rdata_a(sram_rdata_a), .sram_rdata_b(sram_rdata_b), .sram_rdata_c(sram_rdata_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .drain_busy(drain_busy), .drain_done(drain_done), .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] exp_word(input int bank, input int row, input int lane);
    case (bank)
      0:       return 32'hA000_0000 + 32'(row * 256 + lane);
      1:       return 32'(row * 100 + lane);
      default: return 32'hC000_0000 + 32'(row * 256 + lane);
    endcase
  endfunction

  function automatic logic [RW-1:0] make_row(input int bank, input int row);
    logic [RW-1:0] r;
    r = '0;
    for (int l = 0; l < AS; l++) r[l*OW +: OW] = exp_word(bank, row, l);
    return r;
  endfunction

  // Synchronous-read SRAM models: data for the sampled address appears one cycle later.
  always @(posedge clk) begin
    sram_rdata_a <= make_row(0, int'(sram_raddr_a));
    sram_rdata_b <= make_row(1, int'(sram_raddr_b));
    sram_rdata_c <= make_row(2, int'(sram_raddr_c));
  end

  // mode 0: ready held 1; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_drain(input int bank, input int rows, input int mode,
                           input int inject, input int abort_at);
    int cyc, words, busy_cycles, last_hs, done_cnt, row, lane;
    logic stalled, held_l;
    logic [OW-1:0] held_d, sel_addr;
    @(negedge clk);
    drain_start = 1'b1;
    drain_bank  = 2'(bank);
    drain_rows  = 7'(rows);
    out_ready   = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    cyc = 0; words = 0; busy_cycles = 0; last_hs = -10; done_cnt = 0; stalled = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (cyc < 6000 && done_cnt == 0) begin
      if (abort_at >= 0 && words == abort_at && out_valid) return;
      if (drain_busy) busy_cycles++;
      total++;
      if (drain_err !== 1'b0) begin
        bad++; $display("FAIL err_during_drain: got %b want 0 at cycle %0d", drain_err, cyc);
      end
      if (drain_done) begin
        done_cnt++;
        total++;
        if (cyc != last_hs + 1) begin
          bad++; $display("FAIL done_timing: done at cycle %0d, last handshake at %0d", cyc, last_hs);
        end
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b want 1 %h %b", out_valid, out_data, out_last, held_d, held_l);
        end
      end
      drain_start = 1'b0;
      if (inject != 0 && words == 10 && out_valid) begin
        drain_start = 1'b1; drain_bank = 2'd2; drain_rows = 7'd5;
      end
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      row  = words / AS;
      lane = words % AS;
      total++;
      if (out_last !== (out_valid && row == rows - 1 && lane == AS - 1)) begin
        bad++; $display("FAIL last_flag: got %b at word %0d valid=%b", out_last, words, out_valid);
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      if (out_valid && out_ready) begin
        case (bank)
          0: sel_addr = 32'(sram_raddr_a);
          1: sel_addr = 32'(sram_raddr_b);
          default: sel_addr = 32'(sram_raddr_c);
        endcase
        total++;
        if (out_data !== exp_word(bank, row, lane)) begin
          bad++; $display("FAIL word_data: word %0d got %h want %h", words, out_data, exp_word(bank, row, lane));
        end
        total++;
        if (sel_addr !== 32'(row) ||
            (bank != 0 && sram_raddr_a !== '0) || (bank != 1 && sram_raddr_b !== '0) ||
            (bank != 2 && sram_raddr_c !== '0)) begin
          bad++;
          $display("FAIL raddr: a=%0d b=%0d c=%0d want bank %0d at row %0d, others 0", sram_raddr_a, sram_raddr_b, sram_raddr_c, bank, row);
        end
        words++;
        last_hs = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    drain_start = 1'b0;
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL done_seen: got %0d want 1 (timeout %0d cycles)", done_cnt, cyc);
    end
    total++;
    if (words != rows * AS) begin
      bad++; $display("FAIL word_count: got %0d want %0d", words, rows * AS);
    end
    if (mode == 0) begin
      total++;
      if (busy_cycles != rows * (AS + 2) + 1) begin
        bad++; $display("FAIL drain_cycles: got %0d want %0d", busy_cycles, rows * (AS + 2) + 1);
      end
    end
    total++;
    if (drain_busy !== 1'b0 || drain_done !== 1'b0 || out_valid !== 1'b0 || drain_err !== 1'b0) begin
      bad++;
      $display("FAIL post_drain: busy=%b done=%b valid=%b err=%b want 0000", drain_busy, drain_done, out_valid, drain_err);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || drain_busy !== 1'b0 ||
        drain_done !== 1'b0 || drain_err !== 1'b0 || sram_raddr_a !== '0 ||
        sram_raddr_b !== '0 || sram_raddr_c !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b done=%b err=%b raddr=%0d/%0d/%0d want all 0",
               out_valid, out_last, out_data, drain_busy, drain_done, drain_err, sram_raddr_a, sram_raddr_b, sram_raddr_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_send;
    run_drain(0, 3, 0, 0, AS + 5);
    total++;
    if (out_valid !== 1'b1 || sram_raddr_a !== 6'd1) begin
      bad++; $display("FAIL abort_point: valid=%b raddr_a=%0d want 1 1", out_valid, sram_raddr_a);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || drain_busy !== 1'b0 || sram_raddr_a !== '0 ||
        sram_raddr_b !== '0 || sram_raddr_c !== '0) begin
      bad++;
      $display("FAIL reset_mid_send: valid=%b busy=%b raddr=%0d/%0d/%0d want 0", out_valid, drain_busy, sram_raddr_a, sram_raddr_b, sram_raddr_c);
    end
    rst = 1'b0;
    run_drain(0, 1, 0, 0, -1);
  endtask

  task automatic test_two_rows_bank_b;
    run_drain(1, 2, 0, 0, -1);
  endtask

  task automatic test_illegal;
    int banks[3] = '{3, 0, 1};
    int rows[3]  = '{1, 0, 65};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drain_start = 1'b1; drain_bank = 2'(banks[i]); drain_rows = 7'(rows[i]);
      @(negedge clk);
      drain_start = 1'b0;
      total++;
      if (drain_err !== 1'b1 || drain_busy !== 1'b0 || out_valid !== 1'b0 ||
          sram_raddr_a !== 6'd0 || sram_raddr_b !== 6'd1 || sram_raddr_c !== 6'd0) begin
        bad++;
        $display("FAIL illegal_%0d: err=%b busy=%b valid=%b raddr=%0d/%0d/%0d want 1 0 0 0/1/0",
                 i, drain_err, drain_busy, out_valid, sram_raddr_a, sram_raddr_b, sram_raddr_c);
      end
      @(negedge clk);
      total++;
      if (drain_err !== 1'b0 || drain_busy !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL illegal_pulse_%0d: err=%b busy=%b valid=%b want 000", i, drain_err, drain_busy, out_valid);
      end
    end
  endtask

  task automatic test_backpressure_bank_c;
    run_drain(2, 1, 1, 0, -1);
  endtask

  task automatic test_start_while_busy;
    run_drain(1, 2, 0, 1, -1);
  endtask

  task automatic test_full_bank_a;
    run_drain(0, 64, 0, 0, -1);
    total++;
    if (sram_raddr_a !== 6'd63 || sram_raddr_b !== '0 || sram_raddr_c !== '0) begin
      bad++; $display("FAIL full_addr_hold: raddr=%0d/%0d/%0d want 63/0/0", sram_raddr_a, sram_raddr_b, sram_raddr_c);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_two_rows_bank_b();
    test_illegal();
    test_backpressure_bank_c();
    test_start_while_busy();
    test_full_bank_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
